// File: rtl/inst_rom_arbiter_pkg.sv
// inst_rom_arbiter_pkg
//   Shared constants and types for the instruction-ROM arbiter.
//   - arb_owner_e      : owner of the most recent ROM access (IDLE/FETCH/DEBUG)
//   - STARVE_LIMIT_DEF : default number of denied debug cycles before debug is forced
//   - ZERO_WORD, RST_ENABLE, CHIP_ENABLE, CHIP_DISABLE, REG_BUS_W : common CPU constants
package inst_rom_arbiter_pkg;

  localparam int          REG_BUS_W        = 32;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic        RST_ENABLE       = 1'b1;
  localparam logic        CHIP_ENABLE      = 1'b1;
  localparam logic        CHIP_DISABLE     = 1'b0;
  localparam int          STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DEBUG = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/inst_rom_arbiter_starve_cnt.sv
// rom_arb_starve_cnt
//   Saturating 4-bit counter of consecutive cycles in which debug was denied
//   while fetch was granted.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     inc       : debug denied in favour of fetch this cycle
//     clr       : debug granted or not requesting
//     at_limit  : counter has reached LIMIT (debug must win next contention)
module rom_arb_starve_cnt
  import inst_rom_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [3:0] LIMIT_V = 4'(LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter
//   Shares the single-ported instruction ROM between the fetch stage and a
//   debug read port. At most one grant per cycle; fetch has priority unless
//   debug has been starved for STARVE_LIMIT contended cycles. Read data is
//   registered and returned one cycle after the grant.
//   Configuration macro: INST_ROM_ARB_DBG_EN (defined = debug port enabled;
//   undefined = debug port tied off, fetch always granted, stallreq=0).
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     if_req/if_addr/if_gnt         : fetch request, byte address, grant (comb)
//     if_rvalid/if_rdata            : fetch response (registered)
//     dbg_req/dbg_addr/dbg_gnt      : debug request, byte address, grant (comb)
//     dbg_rvalid/dbg_rdata          : debug response (registered)
//     rom_ce/rom_addr/rom_inst      : ROM interface (rom_inst comb in addr/ce)
//     stallreq                      : fetch requested but not granted
//   Handshake: a requester holds req/addr stable until its gnt is high; the
//   transfer completes in the gnt cycle, and the matching rvalid is high for
//   exactly one cycle on the following cycle with rdata alongside.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        stallreq
);

  arb_owner_e  owner_q;
  arb_owner_e  owner_d;
  logic        if_rvalid_q,  if_rvalid_d;
  logic [31:0] if_rdata_q,   if_rdata_d;
  logic        dbg_rvalid_q, dbg_rvalid_d;
  logic [31:0] dbg_rdata_q,  dbg_rdata_d;

`ifdef INST_ROM_ARB_DBG_EN
  logic at_limit;

  rom_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (if_gnt & dbg_req),
    .clr      (dbg_gnt | ~dbg_req),
    .at_limit (at_limit)
  );

  // Fetch wins every contention except when debug has hit its starvation limit.
  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (rst != RST_ENABLE) begin
      if_gnt  = if_req & ~(dbg_req & at_limit);
      dbg_gnt = dbg_req & ~if_gnt;
    end
  end

  assign stallreq = if_req & ~if_gnt;
`else
  // Debug port is tied off; keep its inputs referenced to document intent.
  logic unused_dbg;
  assign unused_dbg = ^{dbg_req, dbg_addr};

  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (rst != RST_ENABLE) begin
      if_gnt = if_req;
    end
  end

  assign stallreq = 1'b0;
`endif

  // ROM drive: address passes through unaligned; the ROM ignores bits [1:0].
  always_comb begin
    rom_ce   = CHIP_DISABLE;
    rom_addr = ZERO_WORD;
    if (if_gnt) begin
      rom_ce   = CHIP_ENABLE;
      rom_addr = if_addr;
`ifdef INST_ROM_ARB_DBG_EN
    end else if (dbg_gnt) begin
      rom_ce   = CHIP_ENABLE;
      rom_addr = dbg_addr;
`endif
    end
  end

  // Owner FSM: the next owner picks which response pair captures rom_inst.
  always_comb begin
    owner_d      = ARB_IDLE;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dbg_rvalid_d = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;
    if (if_gnt) begin
      owner_d = ARB_FETCH;
`ifdef INST_ROM_ARB_DBG_EN
    end else if (dbg_gnt) begin
      owner_d = ARB_DEBUG;
`endif
    end
    case (owner_d)
      ARB_FETCH: begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = rom_inst;
      end
      ARB_DEBUG: begin
        dbg_rvalid_d = 1'b1;
        dbg_rdata_d  = rom_inst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      owner_q      <= ARB_IDLE;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= ZERO_WORD;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= ZERO_WORD;
    end else begin
      owner_q      <= owner_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
`ifdef INST_ROM_ARB_DBG_EN
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
`else
  assign dbg_rvalid = 1'b0;
  assign dbg_rdata  = ZERO_WORD;
`endif

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb_inst_rom_arbiter
//   Directed bench for inst_rom_arbiter. Debug-port vectors are built when
//   INST_ROM_ARB_DBG_EN is defined; the tied-off behaviour is checked otherwise.
module tb_inst_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stallreq;

  int n_vec;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  inst_rom_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .rom_ce     (rom_ce),
    .rom_addr   (rom_addr),
    .rom_inst   (rom_inst),
    .stallreq   (stallreq)
  );

  // ROM model: word i holds a distinctive pattern.
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    return 32'hC0DE_0000 + (idx * 32'h0000_0101);
  endfunction

  assign rom_inst = rom_ce ? rom_word({2'b00, rom_addr[31:2]}) : 32'h0;

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change #1 after posedge; comb outputs are sampled #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da);
    if_req   = ir;
    if_addr  = ia;
    dbg_req  = dr;
    dbg_addr = da;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    step();

    // Reset state
    check_val("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    check_val("rst_if_rdata", if_rdata, 32'h0);
    check_val("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    check_val("rst_dbg_rdata", dbg_rdata, 32'h0);
    check_val("rst_owner", {30'b0, 2'(dut.owner_q)}, 32'd0);
    check_val("rst_rom_ce", {31'b0, rom_ce}, 32'd0);

    rst = 1'b0;
    step();

    // Idle: no request
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check_val("idle_rom_ce", {31'b0, rom_ce}, 32'd0);
    check_val("idle_rom_addr", rom_addr, 32'h0);

    // Fetch only, back-to-back
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 32'h0);
      check_val("fetch_gnt", {31'b0, if_gnt}, 32'd1);
      check_val("fetch_rom_addr", rom_addr, 32'(i * 4));
      check_val("fetch_stall", {31'b0, stallreq}, 32'd0);
      step();
      check_val("fetch_rvalid", {31'b0, if_rvalid}, 32'd1);
      check_val("fetch_rdata", if_rdata, rom_word(32'(i)));
    end

    // Misaligned fetch: address passes through, word index ignores [1:0]
    drive(1'b1, 32'h0000_0015, 1'b0, 32'h0);
    check_val("mis_rom_addr", rom_addr, 32'h0000_0015);
    step();
    check_val("mis_rdata", if_rdata, rom_word(32'd5));

    // Drop request: rvalid falls, rdata holds
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_val("hold_rvalid", {31'b0, if_rvalid}, 32'd0);
    check_val("hold_rdata", if_rdata, rom_word(32'd5));
    check_val("hold_owner", {30'b0, 2'(dut.owner_q)}, 32'd0);

    // Reset during a requested fetch: no grant, no response
    drive(1'b1, 32'h0000_000C, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check_val("rstf_gnt", {31'b0, if_gnt}, 32'd0);
    step();
    check_val("rstf_rvalid", {31'b0, if_rvalid}, 32'd0);
    check_val("rstf_rdata", if_rdata, 32'h0);
    check_val("rstf_owner", {30'b0, 2'(dut.owner_q)}, 32'd0);
    rst = 1'b0;
    #1;
    check_val("resume_gnt", {31'b0, if_gnt}, 32'd1);
    step();
    check_val("resume_rdata", if_rdata, rom_word(32'd3));
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();

`ifdef INST_ROM_ARB_DBG_EN
    // Debug only
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0010);
    check_val("dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    check_val("dbg_rom_addr", rom_addr, 32'h0000_0010);
    step();
    check_val("dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    check_val("dbg_rdata", dbg_rdata, rom_word(32'd4));
    check_val("dbg_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    check_val("dbg_owner", {30'b0, 2'(dut.owner_q)}, 32'd2);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();

    // Continuous contention: fetch x4, debug, fetch
    begin
      logic [5:0] exp_if;
      exp_if = 6'b101111; // bit c = fetch granted in cycle c
      for (int c = 0; c < 6; c++) begin
        drive(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0030);
        check_val("cont_if_gnt", {31'b0, if_gnt}, {31'b0, exp_if[c]});
        check_val("cont_dbg_gnt", {31'b0, dbg_gnt}, {31'b0, ~exp_if[c]});
        check_val("cont_stall", {31'b0, stallreq}, {31'b0, ~exp_if[c]});
        step();
      end
      check_val("cont_if_rvalid", {31'b0, if_rvalid}, 32'd1);
      check_val("cont_dbg_rdata", dbg_rdata, rom_word(32'd12));
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();

    // dbg_req drops in cycle 2 then reasserts: debug waits four more fetches
    begin
      logic [8:0] exp_dbg;
      logic [8:0] dreq;
      dreq    = 9'b111111011;
      exp_dbg = 9'b010000000;
      for (int c = 0; c < 9; c++) begin
        drive(1'b1, 32'h0000_0040, dreq[c], 32'h0000_0044);
        check_val("drop_dbg_gnt", {31'b0, dbg_gnt}, {31'b0, exp_dbg[c]});
        check_val("drop_if_gnt", {31'b0, if_gnt}, {31'b0, ~exp_dbg[c]});
        step();
      end
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();
`else
    // Debug port tied off: fetch always wins, debug never responds
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 32'(c * 4), 1'b1, 32'h0000_0010);
      check_val("off_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
      check_val("off_if_gnt", {31'b0, if_gnt}, 32'd1);
      check_val("off_stall", {31'b0, stallreq}, 32'd0);
      step();
      check_val("off_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
      check_val("off_dbg_rdata", dbg_rdata, 32'h0);
      check_val("off_if_rdata", if_rdata, rom_word(32'(c)));
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_rom_arbiter.md
# inst_rom_arbiter

Shares the single-ported instruction ROM between the CPU fetch stage and a debug read port, which is used by loader/monitor logic to read program memory. The block sits between pc_reg/if_id and inst_rom. It grants at most one requester per cycle, drives the ROM, and returns registered read data one cycle later. Fetch has priority, and a starvation counter guarantees that the debug port eventually gets a grant.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles in which debug is denied while fetch is granted before debug is forced through (range 1–15).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high (`RstEnable`)
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (registered)
- if_rdata  out  32  fetch instruction word
- dbg_req  in  1  debug read request
- dbg_addr  in  32  debug byte address
- dbg_gnt  out  1  debug granted this cycle (combinational)
- dbg_rvalid  out  1  debug data valid (registered)
- dbg_rdata  out  32  debug data word
- rom_ce  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`)
- rom_addr  out  32  ROM byte address
- rom_inst  in  32  ROM data; combinational in rom_addr/rom_ce
- stallreq  out  1  to ctrl; high when if_req=1 and if_gnt=0

## Operation
- Requesters hold req and addr stable until their gnt is high. The transfer completes in the gnt cycle.
- Grant rules, evaluated each cycle:
  - no request: no grant, rom_ce=`ChipDisable`, rom_addr=`ZeroWord`
  - one request: that requester is granted
  - both requesting: fetch is granted unless starve_cnt==STARVE_LIMIT, in which case debug is granted
- starve_cnt (4 bits):
  - increments when both request and fetch is granted
  - clears when debug is granted or dbg_req=0
  - saturates at STARVE_LIMIT
- The owner FSM holds the owner of the last ROM access, with states IDLE, FETCH, DEBUG:
  - next state is FETCH if if_gnt, DEBUG if dbg_gnt, else IDLE
  - the FSM selects which rdata/rvalid pair is loaded
- On the clock edge after a grant:
  - the granted side gets rdata<=rom_inst and rvalid<=1
  - the other side's rvalid<=0 and its rdata holds its previous value
- Misaligned address (addr[1:0]!=0): the access is still granted. rom_addr passes through unchanged; inst_rom ignores bits [1:0].

## Timing
- Reset values:
  - if_rvalid=0, dbg_rvalid=0
  - if_rdata=`ZeroWord`, dbg_rdata=`ZeroWord`
  - starve_cnt=0, FSM=IDLE
  - gnt/rom_ce are combinational but forced inactive while rst=1
- Latency: request granted in cycle N; rvalid/rdata asserted in cycle N+1 for exactly one cycle per grant.
- Back-to-back grants are allowed: full throughput of one access per cycle.
- Reset asserted while an access is in flight drops the pending rvalid. No response is produced after reset.
- Example with continuous contention and STARVE_LIMIT=4: fetch is granted in cycles 0–3, debug in cycle 4, then fetch again.

## Configuration
- INST_ROM_ARB_DBG_EN defined: debug port fully functional as above.
- INST_ROM_ARB_DBG_EN undefined:
  - dbg_req and dbg_addr are ignored
  - dbg_gnt=0, dbg_rvalid=0, dbg_rdata=`ZeroWord`
  - starve_cnt and the DEBUG state are removed
  - fetch is granted whenever if_req=1, and stallreq is constant 0

## Structure
- Put the owner-state encodings (ARB_IDLE, ARB_FETCH, ARB_DEBUG) and the STARVE_LIMIT default in defines.v.
- Reuse the existing `ZeroWord`, `RstEnable`, `ChipEnable`, `ChipDisable` and `RegBus` definitions.
- One sub-module, rom_arb_starve_cnt: the saturating counter with inputs inc and clr, and output at_limit.

## Test plan
- Fetch only, if_addr=0x0,0x4,0x8 in consecutive cycles -> if_gnt=1 each cycle; if_rdata = mem[0],mem[1],mem[2] one cycle later; stallreq=0.
- Debug only, dbg_addr=0x10 -> dbg_gnt=1, rom_addr=0x10; next cycle dbg_rvalid=1, dbg_rdata=mem[4], if_rvalid=0.
- Both requesting continuously, STARVE_LIMIT=4 -> if_gnt in cycles 0–3, dbg_gnt in cycle 4 with stallreq=1 in cycle 4, fetch again in cycle 5.
- dbg_req drops in cycle 2 of contention, then reasserts -> starve_cnt cleared, so debug waits a full 4 fetch grants again.
- rst=1 the cycle after a fetch grant -> if_rvalid stays 0, rdata=0x00000000, FSM=IDLE; normal operation resumes after rst=0.
- INST_ROM_ARB_DBG_EN undefined, dbg_req=1 with if_req=1 -> dbg_gnt never asserts, if_gnt=1 every cycle, stallreq=0.
